uart_tx: RTL



---
 rtl/uart_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit, and a stop bit, one bit per CLK cycle.
// Optional feature macro: UART_TX_STOP2_EN. When it is defined, the frame ends
// with two stop bits.
// TX_OUT and busy are driven straight from flops, so the serial line is glitch-free.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_next_cnt;
    logic [CW-1:0]         w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_next_tx;
    logic                  w_next_busy;
    logic                  w_load;
    logic                  w_parity;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Parity is taken from the latched byte, so mid-frame input changes cannot leak in.
    assign w_parity  = r_par_typ ? ~^r_data : ^r_data;

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

    // State, bit counter and the registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_tx    <= w_next_tx;
            r_busy  <= w_next_busy;
        end
    end

    // Capture the byte and frame format when a request is accepted in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_load) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    // Next state plus the line level and busy for the cycle that state begins.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_tx    = 1'b1;
        w_next_busy  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (Data_Valid) begin
                    w_next_state = START;
                    w_next_tx    = 1'b0;
                    w_next_busy  = 1'b1;
                    w_load       = 1'b1;
                end
            end
            START: begin
                w_next_state = DATA;
                w_next_cnt   = '0;
                w_next_tx    = r_data[0];
                w_next_busy  = 1'b1;
            end
            DATA: begin
                w_next_busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_next_cnt = '0;
                    if (r_par_en) begin
                        w_next_state = PARITY;
                        w_next_tx    = w_parity;
                    end else begin
                        w_next_state = STOP;
                        w_next_tx    = 1'b1;
                    end
                end else begin
                    w_next_cnt = w_cnt_inc;
                    w_next_tx  = r_data[w_cnt_inc];
                end
            end
            PARITY: begin
                w_next_state = STOP;
                w_next_tx    = 1'b1;
                w_next_busy  = 1'b1;
            end
            STOP: begin
`ifdef UART_TX_STOP2_EN
                // The counter marks whether the first of the two stop bits is done.
                if (r_cnt == '0) begin
                    w_next_cnt  = CW'(1);
                    w_next_busy = 1'b1;
                end else begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end
`else
                w_next_state = IDLE;
`endif
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

endmodule
